// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point accumulator.
//   state_t    : accumulator FSM states
//   unpacked_t : {sign, exponent, 24-bit mantissa with hidden bit}
package fp_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, WRITE} state_t;

  localparam int          BIAS           = 127;
  localparam logic [7:0]  EXP_MAX        = 8'd254;
  localparam logic [30:0] MAX_FINITE_MAG = 31'h7F7FFFFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
  } unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational single-precision unpacker.
//   word_i : packed IEEE-754 word
//   op_o   : {sign, exp, hidden bit + fraction}
//   zero_o : exponent field is 0; the word counts as zero and the caller
//            must ignore op_o.mant
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] word_i,
  output unpacked_t   op_o,
  output logic        zero_o
);

  assign zero_o    = (word_i[30:23] == 8'd0);
  assign op_o.sign = word_i[31];
  assign op_o.exp  = word_i[30:23];
  assign op_o.mant = {1'b1, word_i[22:0]};

endmodule

// File: rtl/fp_accumulate.sv
// Sequential single-precision accumulator. Each accepted word is added to a
// running sum through an ALIGN/ADD/NORM/WRITE FSM built around one adder
// and single-bit shifters. A word flagged in_last publishes the sum on
// acc_data with a one-cycle acc_valid pulse and restarts the sum from zero.
//   clk, reset          : clock, asynchronous active-high reset
//   clear               : synchronous abort, zeroes the running sum
//   in_valid/in_ready   : input handshake; in_data/in_last travel with it
//   acc_valid, acc_data : completed-sum pulse and held result
//   busy                : FSM is not in IDLE
module fp_accumulate
  import fp_pkg::*;
#(
  parameter int MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        acc_valid,
  output logic [31:0] acc_data,
  output logic        busy
);

  // Shift count value meaning "smaller operand is dropped entirely".
  localparam logic [7:0] DROP = 8'(MAX_SHIFT + 1);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] acc_data_q, acc_data_d;
  logic        acc_valid_q, acc_valid_d;
  logic        sl_q, sl_d, ss_q, ss_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] ml_q, ml_d, ms_q, ms_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [24:0] res_q, res_d;
  logic        rsign_q, rsign_d;
  logic [31:0] out_q, out_d;

  unpacked_t   ua, ub, opl, ops;
  logic        za, zb, zl, zs, b_big, accept;
  logic [7:0]  diff;

  fp_unpack u_unpack_acc (.word_i(acc_q),   .op_o(ua), .zero_o(za));
  fp_unpack u_unpack_in  (.word_i(in_data), .op_o(ub), .zero_o(zb));

  assign in_ready  = (state_q == IDLE) && !clear;
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign acc_data  = acc_data_q;
  // The pulse is registered; masking with clear keeps it off during an abort.
  assign acc_valid = acc_valid_q && !clear;

  // Operand swap: L carries the larger exponent, accumulator wins a tie.
  always_comb begin
    b_big = (ub.exp > ua.exp);
    opl   = b_big ? ub : ua;
    ops   = b_big ? ua : ub;
    zl    = b_big ? zb : za;
    zs    = b_big ? za : zb;
    diff  = opl.exp - ops.exp;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_data_d  = acc_data_q;
    acc_valid_d = 1'b0;
    sl_d        = sl_q;
    ss_d        = ss_q;
    exp_d       = exp_q;
    ml_d        = ml_q;
    ms_d        = ms_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    res_d       = res_q;
    rsign_d     = rsign_q;
    out_d       = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sl_d    = opl.sign;
          ss_d    = ops.sign;
          exp_d   = opl.exp;
          ml_d    = zl ? 24'd0 : opl.mant;
          ms_d    = zs ? 24'd0 : ops.mant;
          cnt_d   = (diff > 8'(MAX_SHIFT)) ? DROP : diff;
          last_d  = in_last;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (cnt_q == 8'd0) begin
          state_d = ADD;
        end else if (cnt_q == DROP) begin
          ms_d    = 24'd0;
          state_d = ADD;
        end else begin
          ms_d  = ms_q >> 1;
          cnt_d = cnt_q - 8'd1;
        end
      end
      ADD: begin
        if (sl_q == ss_q) begin
          res_d   = {1'b0, ml_q} + {1'b0, ms_q};
          rsign_d = sl_q;
        end else if (ml_q >= ms_q) begin
          res_d   = {1'b0, ml_q} - {1'b0, ms_q};
          rsign_d = sl_q;
        end else begin
          res_d   = {1'b0, ms_q} - {1'b0, ml_q};
          rsign_d = ss_q;
        end
        state_d = NORM;
      end
      NORM: begin
        if (res_q == 25'd0) begin
          out_d   = 32'd0;
          state_d = WRITE;
        end else if (res_q[24]) begin
          // Carry out: one right shift, saturate instead of producing Inf.
          if (exp_q == EXP_MAX) out_d = {rsign_q, MAX_FINITE_MAG};
          else                  out_d = {rsign_q, exp_q + 8'd1, res_q[23:1]};
          state_d = WRITE;
        end else if (res_q[23]) begin
          out_d   = {rsign_q, exp_q, res_q[22:0]};
          state_d = WRITE;
        end else if (exp_q == 8'd1) begin
          // Would underflow into the denormal range: flush to +0.
          out_d   = 32'd0;
          state_d = WRITE;
        end else begin
          res_d = res_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      WRITE: begin
        if (last_q) begin
          acc_data_d  = out_q;
          acc_d       = 32'd0;
          acc_valid_d = 1'b1;
        end else begin
          acc_d = out_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d     = IDLE;
      acc_d       = 32'd0;
      acc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= 32'd0;
      acc_data_q  <= 32'd0;
      acc_valid_q <= 1'b0;
      sl_q        <= 1'b0;
      ss_q        <= 1'b0;
      exp_q       <= 8'd0;
      ml_q        <= 24'd0;
      ms_q        <= 24'd0;
      cnt_q       <= 8'd0;
      last_q      <= 1'b0;
      res_q       <= 25'd0;
      rsign_q     <= 1'b0;
      out_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_data_q  <= acc_data_d;
      acc_valid_q <= acc_valid_d;
      sl_q        <= sl_d;
      ss_q        <= ss_d;
      exp_q       <= exp_d;
      ml_q        <= ml_d;
      ms_q        <= ms_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      res_q       <= res_d;
      rsign_q     <= rsign_d;
      out_q       <= out_d;
    end
  end

endmodule

// File: tb/tb_fp_accumulate.sv
// Directed bench for fp_accumulate: hand-computed sums, busy-cycle latency
// per item, single-cycle acc_valid pulse, clear/reset abort during ALIGN.
module tb_fp_accumulate;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready, in_last, acc_valid, busy;
  logic [31:0] in_data, acc_data;
  int          checks = 0, errors = 0;
  int          lat, n;
  logic        v;

  fp_accumulate #(.MAX_SHIFT(25)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .acc_valid(acc_valid), .acc_data(acc_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one word, wait for the accept, then count busy cycles until IDLE.
  // Returns in the first IDLE cycle with acc_valid sampled there.
  task automatic push(input logic [31:0] d, input logic l, output int blat, output logic vld);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    chk("ready_wait", 32'(w < 200), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    blat = 0;
    @(negedge clk);
    while (busy && blat < 200) begin blat++; @(negedge clk); end
    vld = acc_valid;
  endtask

  // Accept a word and leave the FSM running (used for the abort tests).
  task automatic start(input logic [31:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
    #12;
    @(negedge clk);
    chk("rst_data", acc_data, 32'h0);
    chk("rst_vld", 32'(acc_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // 1.0 + 1.0
    push(32'h3F800000, 1'b0, lat, v);
    chk("t1a_lat", lat, 32'd4);
    push(32'h3F800000, 1'b1, lat, v);
    chk("t1b_lat", lat, 32'd4);
    chk("t1_vld", 32'(v), 32'd1);
    chk("t1_data", acc_data, 32'h40000000);
    @(negedge clk);
    chk("t1_pulse", 32'(acc_valid), 32'd0);

    // 1.0 + 2.0 + 0.5 = 3.5
    push(32'h3F800000, 1'b0, lat, v);
    push(32'h40000000, 1'b0, lat, v);
    chk("t2b_lat", lat, 32'd5);
    push(32'h3F000000, 1'b1, lat, v);
    chk("t2c_lat", lat, 32'd6);
    chk("t2_data", acc_data, 32'h40600000);
    // Accumulator restarted from zero.
    push(32'h3F800000, 1'b1, lat, v);
    chk("t2_restart", acc_data, 32'h3F800000);

    // 1.5 - 1.5 = +0
    push(32'h3FC00000, 1'b0, lat, v);
    push(32'hBFC00000, 1'b1, lat, v);
    chk("t3_lat", lat, 32'd4);
    chk("t3_data", acc_data, 32'h00000000);

    // 1.5 - 1.0 = 0.5, one normalising left shift
    push(32'h3FC00000, 1'b0, lat, v);
    push(32'hBF800000, 1'b1, lat, v);
    chk("t3b_lat", lat, 32'd5);
    chk("t3b_data", acc_data, 32'h3F000000);

    // 1.0 + 2^-30: operand dropped, single ALIGN cycle
    push(32'h3F800000, 1'b0, lat, v);
    push(32'h30800000, 1'b1, lat, v);
    chk("t4_lat", lat, 32'd4);
    chk("t4_data", acc_data, 32'h3F800000);

    // max finite + max finite saturates
    push(32'h7F7FFFFF, 1'b0, lat, v);
    push(32'h7F7FFFFF, 1'b1, lat, v);
    chk("t5_data", acc_data, 32'h7F7FFFFF);

    // clear during a long ALIGN
    push(32'h3F800000, 1'b0, lat, v);
    start(32'h35800000, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    #1 chk("t6_rdy_clr", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    chk("t6_idle", 32'(busy), 32'd0);
    n = 0;
    repeat (30) begin @(negedge clk); if (acc_valid) n++; end
    chk("t6_novld", n, 32'd0);
    push(32'h3F800000, 1'b1, lat, v);
    chk("t6_data", acc_data, 32'h3F800000);

    // clear with in_valid in IDLE: no accept
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("t7_noacc", 32'(busy), 32'd0);
    push(32'h40000000, 1'b1, lat, v);
    chk("t7_data", acc_data, 32'h40000000);

    // async reset during a long ALIGN
    push(32'h3F800000, 1'b0, lat, v);
    start(32'h35800000, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_data", acc_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t8_ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (30) begin @(negedge clk); if (acc_valid) n++; end
    chk("t8_novld", n, 32'd0);
    push(32'h3F800000, 1'b1, lat, v);
    chk("t8_after", acc_data, 32'h3F800000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_accumulate.md
# fp_accumulate

Sequential single-precision floating-point accumulator that sits directly downstream of the `fpMultiplication` stage. It consumes a stream of 32-bit IEEE-754 products over a valid/ready handshake and adds each one into a running sum. It emits the sum when an item flagged `in_last` has been added, then restarts from zero. A multi-cycle align/add/normalize FSM keeps the datapath to one adder and single-bit shifters, which makes it suitable for dot-product style use after the multiplier.

## Interface
- `MAX_SHIFT`, default 25: largest exponent difference that is aligned. For larger differences the smaller operand is dropped.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous abort. Zeroes the accumulator and returns to IDLE.
- `in_valid`  in  1  `in_data` / `in_last` are valid.
- `in_ready`  out  1  block can accept an item.
- `in_data`  in  32  product {sign, exp[7:0], mant[22:0]}.
- `in_last`  in  1  marks the final item of a sequence.
- `acc_valid`  out  1  one-cycle pulse: `acc_data` holds a completed sum.
- `acc_data`  out  32  last completed sum. Held until the next completion.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Number handling:
  - Exponent 0 is treated as zero, with the mantissa ignored.
  - Inf and NaN are not handled specially.
  - Rounding is truncation, matching the multiplier.
- Accept: the item is accepted when `in_valid && in_ready`. `in_ready = (state==IDLE) && !clear`.
- On accept:
  - Operand A is the accumulator and operand B is `in_data`.
  - Each operand is unpacked to {sign, exp, 24-bit mantissa with hidden bit}.
  - The operands are swapped so that L has the larger exponent (on a tie, L = accumulator).
  - `cnt = min(expL-expS, MAX_SHIFT+1)`.
  - `in_last` is latched.
- States:
  - IDLE: waits for an accept, then goes to ALIGN.
  - ALIGN:
    - If `cnt==0`, go to ADD.
    - Else if `cnt==MAX_SHIFT+1`, force S mantissa to 0 and go to ADD.
    - Else shift S mantissa right by 1, decrement `cnt`, and stay in ALIGN.
  - ADD: 25-bit result, then go to NORM.
    - Signs equal: result = mL + mS, with sign sL.
    - Signs differ: result = |mL − mS|, with the sign of the larger magnitude.
  - NORM: one action per cycle.
    - Result 0: give +0 (0x00000000) and go to WRITE.
    - Bit 24 set: shift right by 1 and increment the exponent.
      - If the exponent becomes 255, saturate to {sign, 0xFE, 0x7FFFFF}.
      - Go to WRITE.
    - Bit 23 set: go to WRITE.
    - Otherwise: shift left by 1 and decrement the exponent.
      - If the exponent would reach 0, flush to +0 and go to WRITE.
  - WRITE:
    - The accumulator takes the packed result.
    - If last was latched: `acc_data` takes the result, the accumulator takes 0, and `acc_valid` is set for the next cycle.
    - Go to IDLE.
- `clear`: has priority over all FSM activity. Next state is IDLE, the accumulator becomes 0, and any operation in flight is discarded. `acc_data` is not touched.

## Timing
- Reset values:
  - state IDLE, accumulator 0.
  - `acc_data` 0x00000000, `acc_valid` 0, `busy` 0.
  - `in_ready` is 1 once reset deasserts.
- Take the accept edge as the end of cycle 0:
  - ALIGN occupies cycles 1 … d+1, where d = `cnt`. A dropped operand takes exactly one ALIGN cycle.
  - ADD takes 1 cycle.
  - NORM takes 1 + (left shifts) cycles.
  - WRITE takes 1 cycle.
  - The next cycle is IDLE, with `in_ready`=1 and `acc_valid`=1 if last.
- Example: acc 1.0 + 1.0 with last gives ALIGN c1, ADD c2, NORM c3, WRITE c4, and `acc_valid` in c5.
- `acc_valid` is high for exactly one cycle. It is never high while `clear` or `reset` is asserted.
- Asynchronous reset mid-operation: all state returns to its reset value immediately, and the item in flight is lost.
- `clear` together with `in_valid` in IDLE: no accept happens.

## Structure
- `fp_pkg`:
  - `state_t` enum {IDLE, ALIGN, ADD, NORM, WRITE}.
  - `BIAS`=127, `EXP_MAX`=254, `MAX_FINITE_MAG`=31'h7F7FFFFF.
  - `unpacked_t` struct {sign, exp[7:0], mant[23:0]}.
- Sub-module `fp_unpack` (combinational): splits a word, inserts the hidden bit, and flags zero. Instantiated twice, for the accumulator and for `in_data`.

## Test plan
- 0x3F800000 (1.0) twice, second with last: `acc_data`=0x40000000, `acc_valid` in cycle 5 after the second accept, single pulse.
- 1.0, 2.0 (0x40000000), 0.5 (0x3F000000, last): `acc_data`=0x40600000 (3.5). Accumulator reads 0 afterwards.
- 1.5 (0x3FC00000) then −1.5 (0xBFC00000, last): `acc_data`=0x00000000.
- 1.0 then 0x30800000 (2^−30, last): `acc_data`=0x3F800000, with exactly one ALIGN cycle for the second item.
- 0x7F7FFFFF twice, last: `acc_data`=0x7F7FFFFF (saturation).
- Reset or clear asserted during ALIGN of a long shift (1.0 then 2^−20): FSM is IDLE next cycle, no `acc_valid`; a following 1.0 with last yields 0x3F800000.
